// File: rtl/load_store_unit.sv
// load_store_unit
//   Request-side front end for a word-addressed data memory. Accepts
//   byte-addressed loads/stores over valid/ready, checks alignment and range,
//   converts byte addresses to word indices and performs byte/half stores as
//   a read-modify-write. Load results are sign- or zero-extended.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write/size/unsigned request type: store/load, 00 B 01 H 10 W 11 rsvd
//   req_addr, req_wdata     byte address, store data (low bits for B/H)
//   resp_valid/err/rdata    one-cycle completion, error flag, load result
//   mem_read/mem_write      memory enables, decoded from state
//   mem_addr, mem_wdata     word index and full write word
//   mem_rdata               combinational read data from memory

// One byte lane of the store merge: pick the new byte or keep the old one.
module lsu_merge_lane (
  input  logic       sel_i,
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  output logic [7:0] out_o
);
  assign out_o = sel_i ? new_i : old_i;
endmodule

module load_store_unit #(
  parameter int DEPTH = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE, S_WRITE} state_t;

  // Request attributes needed after transfer. The load/store direction is
  // carried by the state itself, so it is not stored separately.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } lreq_t;

  state_t      state_q;
  lreq_t       lreq_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q, mem_addr_q, mem_wdata_q;

  logic        req_err;
  logic [31:0] rdata_d, wdata_d, shifted, sdata;
  logic [3:0]  be;

  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign shifted = mem_rdata >> {lreq_q.off, 3'b000};

  always_comb begin
    rdata_d = mem_rdata;
    case (lreq_q.size)
      2'b00:   rdata_d = lreq_q.uns ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_d = lreq_q.uns ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_d = mem_rdata;
    endcase
  end

  // Store merge: mem_wdata_q still holds the raw store data during MERGE.
  // Replicate it across lanes and let the byte enables pick the target lane.
  always_comb begin
    if (lreq_q.size == 2'b00) begin
      sdata = {4{mem_wdata_q[7:0]}};
      be    = 4'b0001 << lreq_q.off;
    end else begin
      sdata = {2{mem_wdata_q[15:0]}};
      be    = lreq_q.off[1] ? 4'b1100 : 4'b0011;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    lsu_merge_lane u_lane (
      .sel_i (be[k]),
      .old_i (mem_rdata[8*k +: 8]),
      .new_i (sdata[8*k +: 8]),
      .out_o (wdata_d[8*k +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lreq_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr_q <= {2'b00, req_addr[31:2]};
            lreq_q     <= '{size: req_size, uns: req_unsigned, off: req_addr[1:0]};
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!req_write) begin
              state_q <= S_LOAD;
            end else begin
              mem_wdata_q <= req_wdata;
              state_q     <= (req_size == 2'b10) ? S_WRITE : S_MERGE;
            end
          end
        end
        S_LOAD: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= rdata_d;
          state_q      <= S_IDLE;
        end
        S_MERGE: begin
          mem_wdata_q <= wdata_d;
          state_q     <= S_WRITE;
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // Enables are decoded from state so an async reset drops them at once.
  assign req_ready  = (state_q == S_IDLE);
  assign mem_read   = (state_q == S_LOAD) || (state_q == S_MERGE);
  assign mem_write  = (state_q == S_WRITE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural data memory serves the DUT, and a
// request-level reference model (separate memory image) predicts responses.
module tb_load_store_unit;
  localparam int DEPTH = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Served memory (written by the DUT) and the model's own image.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  assign mem_rdata = (mem_read && mem_addr < 32'(DEPTH)) ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write && mem_addr < 32'(DEPTH)) mem[mem_addr[7:0]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Request-level reference: what the access means, in plain arithmetic.
  function automatic void model(input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a,
                                input logic [31:0] wd, output logic err,
                                output logic [31:0] rd, output int lat,
                                output logic [31:0] nword);
    int          nbits, sh;
    logic [31:0] word, lm, v, mask;
    err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
          (sz == 2'd2 && a % 4 != 0) || (a / 4 >= 32'(DEPTH));
    rd = '0; nword = '0; lat = 1;
    if (err) return;
    word  = ref_mem[a / 4];
    nbits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    sh    = 8 * int'(a % 4);
    lm    = (nbits == 32) ? 32'hFFFF_FFFF : (32'd1 << nbits) - 32'd1;
    if (!wr) begin
      v = (word >> sh) & lm;
      if (!uns && nbits < 32 && v[nbits-1]) v = v | ~lm;
      rd = v; lat = 2; nword = word;
    end else begin
      mask  = lm << sh;
      nword = (word & ~mask) | ((wd << sh) & mask);
      lat   = (nbits == 32) ? 2 : 3;
    end
  endfunction

  // Issue one request from an IDLE cycle and check the whole transaction.
  task automatic apply(input int idx, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input logic eerr, input logic [31:0] erd, input int elat,
                       input logic [31:0] enword);
    int          lat = 0, nwr = 0;
    logic        rseen = 1'b0, gerr = 1'b0;
    logic [31:0] grd = '0, waddr = '0, wword = '0;
    chk("ready", idx, 32'(req_ready), 32'd1);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a;
    req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (mem_read) rseen = 1'b1;
      if (mem_write) begin nwr++; waddr = mem_addr; wword = mem_wdata; end
      if (resp_valid) begin lat = n; gerr = resp_err; grd = resp_rdata; break; end
      @(posedge clk); #1;
    end
    chk("latency", idx, 32'(lat), 32'(elat));
    chk("err", idx, 32'(gerr), 32'(eerr));
    chk("rdata", idx, grd, erd);
    if (eerr) chk("err_access", idx, 32'(rseen) + 32'(nwr), 32'd0);
    else if (wr) begin
      chk("nwrites", idx, 32'(nwr), 32'd1);
      chk("waddr", idx, waddr, a >> 2);
      chk("wword", idx, wword, enword);
      ref_mem[a / 4] = enword;
    end else chk("load_nowrite", idx, 32'(nwr), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        eerr;
    logic [31:0] erd;
    int          elat;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic        merr;
    logic [31:0] mrd, mnw, w;
    int          mlat, bad;

    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom; mem[i] = w; ref_mem[i] = w;
    end
    mem[8] = 32'hF0F0_F0F0; ref_mem[8] = 32'hF0F0_F0F0;
    mem[10] = 32'h0000_0005; ref_mem[10] = 32'h0000_0005;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 0, 32'(resp_err), 32'd0);
    chk("rst_rdata", 0, resp_rdata, 32'd0);
    chk("rst_mem_rw", 0, 32'(mem_read) + 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 0, mem_addr, 32'd0);
    chk("rst_mem_wdata", 0, mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //           wr    sz    uns   addr     wdata          err   rdata          lat
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'd33,  32'h0,         1'b0, 32'hFFFF_FFF0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'd33,  32'h0,         1'b0, 32'h0000_00F0, 2});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'd41,  32'h1234_56AB, 1'b0, 32'h0,         3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'd40,  32'h0,         1'b0, 32'h0000_AB05, 2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'd34,  32'hCDCD_8001, 1'b0, 32'h0,         3});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'd34,  32'h0,         1'b0, 32'hFFFF_8001, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'd32,  32'h0,         1'b0, 32'h0000_F0F0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'd35,  32'h0,         1'b0, 32'hFFFF_FF80, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'd34,  32'h0,         1'b0, 32'h0000_0001, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'd34,  32'h0,         1'b1, 32'h0,         1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'd33,  32'h0,         1'b1, 32'h0,         1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'd32,  32'h0,         1'b1, 32'h0,         1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'd800, 32'h0,         1'b1, 32'h0,         1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'd800, 32'h1111_1111, 1'b1, 32'h0,         1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'd796, 32'h1234_5678, 1'b0, 32'h0,         2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'd796, 32'h0,         1'b0, 32'h1234_5678, 2});

    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, merr, mrd, mlat, mnw);
      apply(i, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
            tbl[i].eerr, tbl[i].erd, tbl[i].elat, mnw);
    end
    chk("word8_after_half", 0, mem[8], 32'h8001_F0F0);

    // Back-to-back word loads with req_valid held high.
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'd32;
    req_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_busy", 0, 32'(req_ready), 32'd0);
    req_addr = 32'd40;
    @(posedge clk); #1;
    chk("b2b_resp1", 0, 32'(resp_valid), 32'd1);
    chk("b2b_accept2", 0, 32'(req_ready), 32'd1);
    chk("b2b_rdata1", 0, resp_rdata, ref_mem[8]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_gap", 0, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp2", 0, 32'(resp_valid), 32'd1);
    chk("b2b_rdata2", 0, resp_rdata, ref_mem[10]);

    // Reset while in WRITE: the write is dropped, no response.
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'd40; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_in_write", 0, 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_write_drop", 0, 32'(mem_write), 32'd0);
    chk("rw_read", 0, 32'(mem_read), 32'd0);
    chk("rw_ready", 0, 32'(req_ready), 32'd1);
    chk("rw_outs", 0, 32'(resp_valid) + 32'(resp_err), 32'd0);
    chk("rw_rdata", 0, resp_rdata, 32'd0);
    chk("rw_addr", 0, mem_addr, 32'd0);
    chk("rw_wdata", 0, mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) bad++;
    end
    chk("rw_no_resp", 0, 32'(bad), 32'd0);
    chk("rw_word10", 0, mem[10], ref_mem[10]);

    // Randomized requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        wr, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      if ($urandom_range(0, 19) == 0) a = $urandom;
      wd = $urandom;
      model(wr, sz, uns, a, wd, merr, mrd, mlat, mnw);
      apply(1000 + i, wr, sz, uns, a, wd, merr, mrd, mlat, mnw);
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_diffs", 0, 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Read and write must never be asserted together.
  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      checks++;
      errors++;
      $display("FAIL rw_overlap got read=%b write=%b expected not both", mem_read, mem_write);
    end
  end

endmodule
